// File: rtl/maxunpool_pkg.sv
// Shared pool/unpool definitions: argmax index encoding
// and the unpool stage FSM state encoding.
package maxunpool_pkg;

  localparam logic [1:0] IDX_TL = 2'd0;
  localparam logic [1:0] IDX_TR = 2'd1;
  localparam logic [1:0] IDX_BL = 2'd2;
  localparam logic [1:0] IDX_BR = 2'd3;

  typedef enum logic [2:0] {
    ACCEPT,
    TOP_L,
    TOP_R,
    BOT_L,
    BOT_R
  } state_t;

endpackage

// File: rtl/unpool_line_buf.sv
// Single-port line buffer: synchronous write, asynchronous read,
// both at the same address.
module unpool_line_buf #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 18,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/maxunpool_stream.sv
// Streaming 2x2 max-unpool: each pooled element expands to a 2x2
// window with the value at its argmax slot, emitted in raster order.
module maxunpool_stream
  import maxunpool_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int POOL_COLS  = 8,
  parameter int POOL_ROWS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last_col,
  output logic                  out_last_frame
);

  localparam int CW = (POOL_COLS > 1) ? $clog2(POOL_COLS) : 1;
  localparam int RW = (POOL_ROWS > 1) ? $clog2(POOL_ROWS) : 1;
  localparam int BW = DATA_WIDTH + 2;
  localparam logic [CW-1:0] LAST_COL = CW'(POOL_COLS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(POOL_ROWS - 1);

  state_t                r_state;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_prow;
  logic [DATA_WIDTH-1:0] r_hold_val;
  logic [1:0]            r_hold_idx;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_last_col;
  logic                  r_last_frame;

  logic                  w_in_xfer;
  logic                  w_col_last;
  logic                  w_row_last;
  logic [CW-1:0]         w_addr;
  logic [BW-1:0]         w_rdata;
  logic [DATA_WIDTH-1:0] w_buf_val;
  logic [1:0]            w_buf_idx;

  assign in_ready   = rst_n && (r_state == ACCEPT);
  assign w_in_xfer  = in_valid && in_ready;
  assign w_col_last = (r_col == LAST_COL);
  assign w_row_last = (r_prow == LAST_ROW);
  assign w_buf_val  = w_rdata[DATA_WIDTH-1:0];
  assign w_buf_idx  = w_rdata[BW-1:DATA_WIDTH];

  // Address the entry the next bottom-row pixel will need.
  always_comb begin
    w_addr = r_col;
    case (r_state)
      TOP_R:   if (w_col_last) w_addr = '0;
      BOT_R:   w_addr = r_col + 1'b1;
      default: w_addr = r_col;
    endcase
  end

  unpool_line_buf #(
    .DEPTH (POOL_COLS),
    .WIDTH (BW),
    .AW    (CW)
  ) u_line_buf (
    .clk     (clk),
    .i_we    (w_in_xfer),
    .i_addr  (w_addr),
    .i_wdata ({in_idx, in_data}),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ACCEPT;
      r_col        <= '0;
      r_prow       <= '0;
      r_hold_val   <= '0;
      r_hold_idx   <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_last_col   <= 1'b0;
      r_last_frame <= 1'b0;
    end else begin
      unique case (r_state)
        ACCEPT: if (w_in_xfer) begin
          r_hold_val  <= in_data;
          r_hold_idx  <= in_idx;
          r_out_valid <= 1'b1;
          r_out_data  <= (in_idx == IDX_TL) ? in_data : '0;
          r_state     <= TOP_L;
        end
        TOP_L: if (out_ready) begin
          r_out_data <= (r_hold_idx == IDX_TR) ? r_hold_val : '0;
          r_last_col <= w_col_last;
          r_state    <= TOP_R;
        end
        TOP_R: if (out_ready) begin
          r_last_col <= 1'b0;
          if (w_col_last) begin
            r_col      <= '0;
            r_out_data <= (w_buf_idx == IDX_BL) ? w_buf_val : '0;
            r_state    <= BOT_L;
          end else begin
            r_col       <= r_col + 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_state     <= ACCEPT;
          end
        end
        BOT_L: if (out_ready) begin
          r_out_data   <= (w_buf_idx == IDX_BR) ? w_buf_val : '0;
          r_last_col   <= w_col_last;
          r_last_frame <= w_col_last && w_row_last;
          r_state      <= BOT_R;
        end
        BOT_R: if (out_ready) begin
          r_last_col   <= 1'b0;
          r_last_frame <= 1'b0;
          if (w_col_last) begin
            r_col       <= '0;
            r_prow      <= w_row_last ? '0 : r_prow + 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_state     <= ACCEPT;
          end else begin
            r_col      <= r_col + 1'b1;
            r_out_data <= (w_buf_idx == IDX_BL) ? w_buf_val : '0;
            r_state    <= BOT_L;
          end
        end
        default: r_state <= ACCEPT;
      endcase
    end
  end

  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign out_last_col   = r_last_col;
  assign out_last_frame = r_last_frame;

endmodule

// File: tb/tb_maxunpool_stream.sv
// Self-checking bench for maxunpool_stream: table-driven frames,
// queue scoreboard, backpressure, reset and wide-row checks.
module tb_maxunpool_stream;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  idx;
    logic [15:0] e_tl, e_tr, e_bl, e_br;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        lc;
    logic        lf;
  } pix_t;

  vec_t vecs[12];
  pix_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic        out_last_col, out_last_frame;
  logic [15:0] in_data, out_data;
  logic [1:0]  in_idx;

  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic        lc2, lf2;
  logic [15:0] in_data2, d2;
  logic [1:0]  in_idx2;

  maxunpool_stream #(.DATA_WIDTH(16), .POOL_COLS(2), .POOL_ROWS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_idx(in_idx),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last_col(out_last_col),
    .out_last_frame(out_last_frame)
  );

  maxunpool_stream #(.DATA_WIDTH(16), .POOL_COLS(8), .POOL_ROWS(2)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .in_idx(in_idx2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(d2), .out_last_col(lc2),
    .out_last_frame(lf2)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // out_ready pattern: mode 0 always 1, mode 1 repeats 1,0,0,1
  int ready_mode = 0;
  int rcnt = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 0) out_ready = 1'b1;
      else begin
        out_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
        rcnt++;
      end
    end
  end

  // Main monitor/scoreboard for the 2x2 instance
  bit          stalled = 0;
  bit          prev_lf = 0;
  logic [18:0] st_snap;
  int          lf_cnt = 0;
  int          xfer_cnt = 0;
  initial forever begin
    pix_t p;
    @(negedge clk);
    if (!rst_n) begin
      stalled = 0;
      prev_lf = 0;
    end else begin
      if (stalled)
        chk("stall_hold",
            32'({out_valid, out_last_col, out_last_frame, out_data}),
            32'(st_snap));
      if (prev_lf) chk("frame_wrap_in_ready", 32'(in_ready), 32'd1);
      prev_lf = 0;
      if (out_valid) chk("in_ready_busy", 32'(in_ready), 32'd0);
      else chk("idle_zero", 32'({out_data, out_last_col, out_last_frame}), 32'd0);
      stalled = out_valid && !out_ready;
      st_snap = {out_valid, out_last_col, out_last_frame, out_data};
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) chk("unexpected_pixel", 32'(exp_q.size()), 32'd1);
        else begin
          p = exp_q.pop_front();
          chk("pixel", 32'({out_last_col, out_last_frame, out_data}),
              32'({p.lc, p.lf, p.d}));
        end
        if (out_last_frame) begin
          lf_cnt++;
          prev_lf = 1;
        end
      end
    end
  end

  // Monitor for the 8-column instance: one pooled row, 32 pixels
  int p2 = 0;
  initial forever begin
    int col, row;
    @(negedge clk);
    if (rst_n && out_valid2 && out_ready2) begin
      col = p2 % 16;
      row = p2 / 16;
      chk("w8_last_col", 32'(lc2), 32'(col == 15));
      chk("w8_last_frame", 32'(lf2), 32'd0);
      if (row == 1 && col == 14) chk("w8_max_px", 32'(d2), 32'hFFFF);
      else chk("w8_zero_px", 32'(d2), 32'd0);
      p2++;
    end
  end

  task automatic send(input logic [15:0] d, input logic [1:0] idx,
                      input int gap);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_idx   = idx;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    chk("input_accept", 32'(ok), 32'd1);
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic push_row(input int base, input bit last_row);
    for (int c = 0; c < 2; c++) begin
      exp_q.push_back(pix_t'{vecs[base+c].e_tl, 1'b0, 1'b0});
      exp_q.push_back(pix_t'{vecs[base+c].e_tr, c == 1, 1'b0});
    end
    for (int c = 0; c < 2; c++) begin
      exp_q.push_back(pix_t'{vecs[base+c].e_bl, 1'b0, 1'b0});
      exp_q.push_back(pix_t'{vecs[base+c].e_br, c == 1, last_row && c == 1});
    end
  endtask

  task automatic run_frame(input int base, input int gap);
    for (int r = 0; r < 2; r++) begin
      push_row(base + 2 * r, r == 1);
      for (int c = 0; c < 2; c++)
        send(vecs[base+2*r+c].d, vecs[base+2*r+c].idx, gap);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && exp_q.size() > 0; t++) @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic send2(input logic [15:0] d, input logic [1:0] idx);
    bit ok = 0;
    in_valid2 = 1'b1;
    in_data2  = d;
    in_idx2   = idx;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready2;
      @(posedge clk); #1;
    end
    chk("w8_input_accept", 32'(ok), 32'd1);
  endtask

  initial begin
    int lf0, x0;
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lf0, x0;
    vecs[0]  = '{16'h0011, 2'd0, 16'h0011, 16'h0000, 16'h0000, 16'h0000};
    vecs[1]  = '{16'h0022, 2'd1, 16'h0000, 16'h0022, 16'h0000, 16'h0000};
    vecs[2]  = '{16'h0033, 2'd2, 16'h0000, 16'h0000, 16'h0033, 16'h0000};
    vecs[3]  = '{16'h0044, 2'd3, 16'h0000, 16'h0000, 16'h0000, 16'h0044};
    for (int i = 4; i < 8; i++)
      vecs[i] = '{16'hAAAA, 2'd3, 16'h0000, 16'h0000, 16'h0000, 16'hAAAA};
    vecs[8]  = '{16'h1234, 2'd1, 16'h0000, 16'h1234, 16'h0000, 16'h0000};
    vecs[9]  = '{16'hBEEF, 2'd2, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000};
    vecs[10] = '{16'h0000, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[11] = '{16'hFFFF, 2'd0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_idx = '0;
    in_valid2 = 1'b0; in_data2 = '0; in_idx2 = '0; out_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_outputs",
        32'({out_valid, out_last_col, out_last_frame, out_data}), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);

    // single frame, no backpressure
    run_frame(0, 0);
    in_valid = 1'b0;
    drain();

    // backpressure 1-0-0-1
    ready_mode = 1;
    run_frame(0, 0);
    in_valid = 1'b0;
    drain();
    ready_mode = 0;

    // back-to-back frames
    lf0 = lf_cnt;
    run_frame(8, 0);
    run_frame(0, 0);
    in_valid = 1'b0;
    drain();
    chk("last_frame_count", 32'(lf_cnt - lf0), 32'd2);

    // idle gaps between inputs
    run_frame(0, 5);
    drain();

    // reset during BOT_L of pooled row 0
    x0 = xfer_cnt;
    exp_q.push_back(pix_t'{16'h0011, 1'b0, 1'b0});
    exp_q.push_back(pix_t'{16'h0000, 1'b0, 1'b0});
    exp_q.push_back(pix_t'{16'h0000, 1'b0, 1'b0});
    exp_q.push_back(pix_t'{16'h0022, 1'b1, 1'b0});
    send(16'h0011, 2'd0, 0);
    send(16'h0022, 2'd1, 0);
    in_valid = 1'b0;
    for (int t = 0; t < 100 && xfer_cnt < x0 + 4; t++) @(negedge clk);
    chk("top_row_done", 32'(xfer_cnt - x0), 32'd4);
    @(posedge clk); #1;
    chk("in_bot_l_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    chk("midreset_outputs",
        32'({out_valid, out_last_col, out_last_frame, out_data}), 32'd0);
    chk("midreset_in_ready_low", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("midreset_accept", 32'(in_ready), 32'd1);
    run_frame(4, 0);
    in_valid = 1'b0;
    drain();

    // 8-column instance: 0xFFFF, idx=2 in pooled column 7
    for (int c = 0; c < 8; c++)
      if (c == 7) send2(16'hFFFF, 2'd2);
      else send2(16'h0000, 2'd0);
    in_valid2 = 1'b0;
    for (int t = 0; t < 200 && p2 < 32; t++) @(negedge clk);
    chk("w8_pixel_count", 32'(p2), 32'd32);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
